// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - IF/ID pipeline latch with early branch/jump resolution and hazard stall
//
// Purpose: holds the fetched PC/instruction for decode, resolves beq/bne/j/jal/jr in ID,
// detects load-use and branch-operand hazards, flushes the wrong-path fetch behind a taken
// branch/jump and latches a sticky HALT on 32'hFFFF_FFFF.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   pc_in, instr_in          fetch PC and instruction
//   rs_data, rt_data         register/forwarded operands of the instruction in ID
//   ex_reg_write, ex_mem_read, ex_dest   EX-stage writer/load and its destination
//   mem_mem_read, mem_dest   MEM-stage load and its destination
//   id_pc, id_instr          latched PC/instruction in ID
//   id_valid                 live instruction presented to EX (0 during bubbles)
//   stall                    hold PC and IF/ID, bubble to EX
//   branch_taken, branch_offset   taken branch and sign-extended word offset
//   jump_taken, new_addr     taken jump and its absolute target
//   halted                   sticky halt flag
//   stall_cnt, flush_cnt     saturating performance counters
module if_id_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pc_in,
  input  logic [31:0]      instr_in,
  input  logic [31:0]      rs_data,
  input  logic [31:0]      rt_data,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_dest,
  input  logic             mem_mem_read,
  input  logic [4:0]       mem_dest,
  output logic [31:0]      id_pc,
  output logic [31:0]      id_instr,
  output logic             id_valid,
  output logic             stall,
  output logic             branch_taken,
  output logic [31:0]      branch_offset,
  output logic             jump_taken,
  output logic [31:0]      new_addr,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  state_t state_q, state_d;
  logic   valid_q;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        is_beq, is_bne, is_j, is_jal, is_jr, is_halt;
  logic        reads_operands;
  logic        use_rs, use_rt;
  logic        ex_hit, mem_hit;
  logic        hazard;
  logic        ctrl_en;
  logic        in_run;
  logic [31:0] jump_region;

  assign opcode = id_instr[31:26];
  assign funct  = id_instr[5:0];
  assign rs     = id_instr[25:21];
  assign rt     = id_instr[20:16];

  assign is_beq  = (opcode == 6'b000100);
  assign is_bne  = (opcode == 6'b000101);
  assign is_j    = (opcode == 6'b000010);
  assign is_jal  = (opcode == 6'b000011);
  assign is_jr   = (opcode == 6'b000000) && (funct == 6'b001000);
  assign is_halt = (id_instr == 32'hFFFF_FFFF);

  // Instructions resolved in ID need their operands now, not at EX.
  assign reads_operands = is_beq | is_bne | is_jr;

  assign use_rs = ~(is_j | is_jal);
  assign use_rt = is_beq | is_bne | ((opcode == 6'b000000) & ~is_jr);

  // $0 is hard-wired, so a write to it can never be a true dependency.
  assign ex_hit  = (ex_dest != 5'd0) &&
                   ((use_rs && (ex_dest == rs)) || (use_rt && (ex_dest == rt)));
  assign mem_hit = (mem_dest != 5'd0) &&
                   ((use_rs && (mem_dest == rs)) || (use_rt && (mem_dest == rt)));

  assign hazard = valid_q &
                  ((ex_mem_read & ex_hit) |
                   (reads_operands & ((ex_reg_write & ex_hit) | (mem_mem_read & mem_hit))));

  assign in_run = (state_q == ST_RUN);

  // Upper nibble of the sequential PC selects the 256 MB region of a j/jal target.
  assign jump_region = (id_pc + 32'd4) & 32'hF000_0000;

  always_comb begin
    stall         = 1'b1;
    halted        = 1'b0;
    ctrl_en       = 1'b0;
    branch_taken  = 1'b0;
    jump_taken    = 1'b0;
    id_valid      = 1'b0;
    branch_offset = {{16{id_instr[15]}}, id_instr[15:0]};
    new_addr      = is_jr ? rs_data : (jump_region | {4'b0000, id_instr[25:0], 2'b00});
    state_d       = state_q;

    if (in_run) begin
      stall    = hazard;
      // Control is suppressed while stalled, which gives stall priority over flush.
      ctrl_en  = valid_q & ~hazard;
      id_valid = ctrl_en;
      branch_taken = ctrl_en & ((is_beq & (rs_data == rt_data)) |
                                (is_bne & (rs_data != rt_data)));
      jump_taken   = ctrl_en & (is_j | is_jal | is_jr);
      if (ctrl_en && is_halt) begin
        state_d = ST_HALT;
      end
    end else begin
      halted = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_pc    <= 32'd0;
      id_instr <= 32'd0;
      valid_q  <= 1'b0;
    end else if (in_run && !stall) begin
      id_pc    <= pc_in;
      id_instr <= instr_in;
      // The fetch behind a taken branch/jump is wrong-path: keep it but mark it dead.
      valid_q  <= ~(branch_taken | jump_taken);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (in_run) begin
      if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if ((branch_taken || jump_taken) && (flush_cnt != {CNT_W{1'b1}})) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - randomized and directed self-checking bench for if_id_stage
module tb_if_id_stage;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [31:0]      pc_in = 32'd0;
  logic [31:0]      instr_in = 32'd0;
  logic [31:0]      rs_data = 32'd0;
  logic [31:0]      rt_data = 32'd0;
  logic             ex_reg_write = 1'b0;
  logic             ex_mem_read = 1'b0;
  logic [4:0]       ex_dest = 5'd0;
  logic             mem_mem_read = 1'b0;
  logic [4:0]       mem_dest = 5'd0;
  logic [31:0]      id_pc, id_instr, branch_offset, new_addr;
  logic             id_valid, stall, branch_taken, jump_taken, halted;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  if_id_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .instr_in(instr_in),
    .rs_data(rs_data), .rt_data(rt_data),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_dest(ex_dest),
    .mem_mem_read(mem_mem_read), .mem_dest(mem_dest),
    .id_pc(id_pc), .id_instr(id_instr), .id_valid(id_valid), .stall(stall),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump_taken(jump_taken), .new_addr(new_addr), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [31:0]      m_pc, m_instr;
  logic             m_valid, m_halted;
  logic [CNT_W-1:0] m_scnt, m_fcnt;
  // reference model outputs for the current cycle
  logic             e_stall, e_bt, e_jt, e_idv, e_halt_go;
  logic [31:0]      e_off, e_na;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset;
    m_pc = 32'd0; m_instr = 32'd0; m_valid = 1'b0; m_halted = 1'b0;
    m_scnt = '0; m_fcnt = '0;
  endtask

  task automatic model_eval;
    logic [5:0]  op;
    logic [4:0]  rs, rt;
    logic        beq, bne, j, jal, jr, hlt, use_rs, use_rt, hit_ex, hit_mem, haz, live;
    logic [31:0] seq;
    op  = m_instr[31:26];
    rs  = m_instr[25:21];
    rt  = m_instr[20:16];
    beq = (op == 6'd4);
    bne = (op == 6'd5);
    j   = (op == 6'd2);
    jal = (op == 6'd3);
    jr  = (op == 6'd0) && (m_instr[5:0] == 6'd8);
    hlt = (m_instr == 32'hFFFF_FFFF);
    use_rs  = !(j || jal);
    use_rt  = beq || bne || (op == 6'd0 && !jr);
    hit_ex  = ex_dest != 0 && ((use_rs && ex_dest == rs) || (use_rt && ex_dest == rt));
    hit_mem = mem_dest != 0 && ((use_rs && mem_dest == rs) || (use_rt && mem_dest == rt));
    haz = m_valid && ((ex_mem_read && hit_ex) ||
                      ((beq || bne || jr) && ((ex_reg_write && hit_ex) || (mem_mem_read && hit_mem))));
    live      = m_valid && !haz && !m_halted;
    e_stall   = m_halted || haz;
    e_idv     = live;
    e_bt      = live && ((beq && rs_data == rt_data) || (bne && rs_data != rt_data));
    e_jt      = live && (j || jal || jr);
    e_halt_go = live && hlt;
    e_off     = {{16{m_instr[15]}}, m_instr[15:0]};
    seq       = m_pc + 32'd4;
    e_na      = jr ? rs_data : {seq[31:28], m_instr[25:0], 2'b00};
  endtask

  task automatic model_tick;
    if (!m_halted) begin
      if (e_stall) begin
        if (m_scnt != CMAX) m_scnt = m_scnt + 1'b1;
      end else begin
        if ((e_bt || e_jt) && m_fcnt != CMAX) m_fcnt = m_fcnt + 1'b1;
        m_valid = !(e_bt || e_jt);
        m_pc    = pc_in;
        m_instr = instr_in;
        m_halted = e_halt_go;
      end
    end
  endtask

  task automatic compare_all;
    check("id_pc", id_pc, m_pc);
    check("id_instr", id_instr, m_instr);
    check("id_valid", {31'd0, id_valid}, {31'd0, e_idv});
    check("stall", {31'd0, stall}, {31'd0, e_stall});
    check("branch_taken", {31'd0, branch_taken}, {31'd0, e_bt});
    check("branch_offset", branch_offset, e_off);
    check("jump_taken", {31'd0, jump_taken}, {31'd0, e_jt});
    check("new_addr", new_addr, e_na);
    check("halted", {31'd0, halted}, {31'd0, m_halted});
    check("stall_cnt", {{(32-CNT_W){1'b0}}, stall_cnt}, {{(32-CNT_W){1'b0}}, m_scnt});
    check("flush_cnt", {{(32-CNT_W){1'b0}}, flush_cnt}, {{(32-CNT_W){1'b0}}, m_fcnt});
  endtask

  // Called at a negedge: drive inputs, let logic settle, compare against the model.
  task automatic apply(input logic [31:0] pc, input logic [31:0] ins,
                       input logic [31:0] rsd, input logic [31:0] rtd,
                       input logic exrw, input logic exmr, input logic [4:0] exd,
                       input logic mmr, input logic [4:0] md);
    pc_in = pc; instr_in = ins; rs_data = rsd; rt_data = rtd;
    ex_reg_write = exrw; ex_mem_read = exmr; ex_dest = exd;
    mem_mem_read = mmr; mem_dest = md;
    #1;
    model_eval();
    compare_all();
  endtask

  task automatic apply_plain(input logic [31:0] pc, input logic [31:0] ins);
    apply(pc, ins, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
  endtask

  task automatic tick;
    @(posedge clk);
    model_tick();
    @(negedge clk);
  endtask

  // Asserts rst between clock edges and checks outputs drop before any edge.
  task automatic async_reset;
    #2 rst = 1'b1;
    model_reset();
    #1;
    model_eval();
    compare_all();
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_id_valid", {31'd0, id_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] a, b, c;
    a = 5'($urandom_range(0, 3));
    b = 5'($urandom_range(0, 3));
    c = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 9))
      0: return {6'b000100, a, b, 16'($urandom)};
      1: return {6'b000101, a, b, 16'($urandom)};
      2: return {6'b000010, 26'($urandom)};
      3: return {6'b000011, 26'($urandom)};
      4: return {6'b000000, a, 15'd0, 6'b001000};
      5: return {6'b100011, a, b, 16'($urandom)};
      6: return {6'b000000, a, b, c, 5'd0, 6'b100000};
      7: return {6'b001000, a, b, 16'($urandom)};
      8: return ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFF : {6'b001000, a, b, 16'd4};
      default: return $urandom;
    endcase
  endfunction

  localparam logic [31:0] NOP     = 32'h0000_0000;
  localparam logic [31:0] ADD_R8  = 32'h0109_5020;  // add $10,$8,$9
  localparam logic [31:0] BEQ_55  = 32'h10A5_FFFE;  // beq $5,$5,-2
  localparam logic [31:0] J_40    = 32'h0800_0040;  // j 0x40
  localparam logic [31:0] JR_4    = 32'h0080_0008;  // jr $4
  localparam logic [31:0] BNE_9   = 32'h1520_0003;  // bne $9,$0,3
  localparam logic [31:0] HALT_I  = 32'hFFFF_FFFF;

  initial begin
    int halt_cycles;
    model_reset();
    @(negedge clk);
    model_eval();
    compare_all();
    rst = 1'b0;

    // load-use stall on add after lw $8
    apply_plain(32'h100, ADD_R8); tick();
    apply(32'h104, NOP, 0, 0, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0);
    check("lu_stall", {31'd0, stall}, 32'd1);
    check("lu_id_valid", {31'd0, id_valid}, 32'd0);
    tick();
    apply_plain(32'h104, NOP);
    check("lu_pc_held", id_pc, 32'h100);
    check("lu_id_valid_after", {31'd0, id_valid}, 32'd1);
    check("lu_stall_cnt", {24'd0, stall_cnt}, 32'd1);
    tick();

    // stall counter saturation: hold the load-use condition
    apply_plain(32'h108, ADD_R8); tick();
    for (int i = 0; i < 300; i++) begin
      apply(32'h10C, NOP, 0, 0, 1'b0, 1'b1, 5'd8, 1'b0, 5'd0);
      tick();
    end
    apply_plain(32'h10C, NOP);
    check("stall_cnt_sat", {24'd0, stall_cnt}, {24'd0, CMAX});
    tick();

    // taken beq with negative offset, then flushed slot
    async_reset();
    apply_plain(32'h200, BEQ_55); tick();
    apply(32'h204, ADD_R8, 32'd7, 32'd7, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    check("beq_taken", {31'd0, branch_taken}, 32'd1);
    check("beq_offset", branch_offset, 32'hFFFF_FFFE);
    tick();
    apply_plain(32'h1FC, NOP);
    check("beq_flush_valid", {31'd0, id_valid}, 32'd0);
    check("beq_flush_cnt", {24'd0, flush_cnt}, 32'd1);
    tick();

    // j and jr targets
    async_reset();
    apply_plain(32'h10, J_40); tick();
    apply_plain(32'h14, JR_4);
    check("j_taken", {31'd0, jump_taken}, 32'd1);
    check("j_addr", new_addr, 32'h0000_0100);
    tick();
    apply_plain(32'h18, JR_4); tick();
    apply(32'h1C, NOP, 32'h20, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    check("jr_taken", {31'd0, jump_taken}, 32'd1);
    check("jr_addr", new_addr, 32'h0000_0020);
    tick();

    // lw $9 followed by bne $9: H1 then H3, resolved on third cycle
    async_reset();
    apply_plain(32'h300, BNE_9); tick();
    apply(32'h304, NOP, 32'd5, 32'd0, 1'b1, 1'b1, 5'd9, 1'b0, 5'd0);
    check("lb_stall1", {31'd0, stall}, 32'd1);
    check("lb_bt1", {31'd0, branch_taken}, 32'd0);
    tick();
    apply(32'h304, NOP, 32'd5, 32'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd9);
    check("lb_stall2", {31'd0, stall}, 32'd1);
    check("lb_bt2", {31'd0, branch_taken}, 32'd0);
    tick();
    apply(32'h304, NOP, 32'd5, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    check("lb_bt3", {31'd0, branch_taken}, 32'd1);
    check("lb_stall_cnt", {24'd0, stall_cnt}, 32'd2);
    tick();

    // halt is sticky for 100 cycles regardless of inputs
    async_reset();
    apply_plain(32'h400, HALT_I); tick();
    apply_plain(32'h404, NOP); tick();
    for (int i = 0; i < 100; i++) begin
      apply($urandom, rand_instr(), $urandom, $urandom, 1'($urandom), 1'($urandom),
            5'($urandom), 1'($urandom), 5'($urandom));
      tick();
    end
    apply_plain(32'h408, NOP);
    check("halt_sticky", {31'd0, halted}, 32'd1);
    check("halt_stall", {31'd0, stall}, 32'd1);
    async_reset();
    check("halt_cleared", {31'd0, halted}, 32'd0);

    // first edge after reset release latches pc_in as live
    apply_plain(32'h40, NOP); tick();
    check("rel_pc", id_pc, 32'h40);
    check("rel_valid", {31'd0, id_valid}, 32'd1);

    // randomized run with occasional resets
    halt_cycles = 0;
    for (int i = 0; i < 800; i++) begin
      logic [31:0] a, b;
      a = 32'($urandom_range(0, 2));
      b = ($urandom_range(0, 1) == 0) ? a : $urandom;
      apply($urandom & 32'hFFFF_FFFC, rand_instr(), a, b,
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 3)));
      if (m_halted) halt_cycles++;
      if (halt_cycles > 4 || $urandom_range(0, 99) == 0) begin
        halt_cycles = 0;
        async_reset();
      end else begin
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
